// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the digit-serial multiplier controller.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int digits_of(input int width);
        return width / 2;
    endfunction

    // Digit counters never collapse to zero bits, even for a single digit.
    function automatic int cnt_width(input int digits);
        if (digits <= 1) begin
            return 1;
        end else begin
            return $clog2(digits);
        end
    endfunction

endpackage

// File: rtl/twobitmultiplier.sv
// Combinational 2x2-bit unsigned multiplier cell: P = {A1,A0} * {B1,B0}.
module twobitmultiplier (
    input  logic       A0,
    input  logic       A1,
    input  logic       B0,
    input  logic       B1,
    output logic [3:0] P
);

    logic cross_carry_s;

    // Half-adder array over the four bit products
    always_comb begin
        cross_carry_s = A1 & B0 & A0 & B1;
        P[0]          = A0 & B0;
        P[1]          = (A1 & B0) ^ (A0 & B1);
        P[2]          = (A1 & B1) ^ cross_carry_s;
        P[3]          = A1 & B1 & cross_carry_s;
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Digit-serial unsigned multiplier: one 2x2 cell stepped over all digit pairs.
// Build option MULT_ZERO_SKIP_EN: zero operands finish one cycle after accept.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int DIGITS = digits_of(WIDTH);
    localparam int CW     = cnt_width(DIGITS);
    localparam int PW     = 2 * WIDTH;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);
    localparam logic [CW-1:0] ONE_DIGIT  = CW'(1);

    if (((WIDTH % 2) != 0) || (WIDTH < 2)) begin : g_width_check
        $error("mult_seq_ctrl: WIDTH must be even and at least 2");
    end

    state_t            state_r;
    logic [WIDTH-1:0]  a_reg_r;
    logic [WIDTH-1:0]  b_reg_r;
    logic [CW-1:0]     i_r;
    logic [CW-1:0]     j_r;
    logic [PW-1:0]     acc_r;
    logic [1:0]        a_dig_s;
    logic [1:0]        b_dig_s;
    logic [3:0]        pp_s;
    logic [CW+1:0]     shift_s;
    logic [PW-1:0]     pp_ext_s;
    logic [PW-1:0]     acc_next_s;
    logic              zero_hit_s;

    // Digit selection, partial-product alignment and the next accumulator value
    always_comb begin
        a_dig_s        = 2'(a_reg_r >> {i_r, 1'b0});
        b_dig_s        = 2'(b_reg_r >> {j_r, 1'b0});
        shift_s        = {({1'b0, i_r} + {1'b0, j_r}), 1'b0};
        pp_ext_s       = '0;
        pp_ext_s[3:0]  = pp_s;
        acc_next_s     = acc_r + (pp_ext_s << shift_s);
`ifdef MULT_ZERO_SKIP_EN
        zero_hit_s     = (a_reg_r == '0) || (b_reg_r == '0);
`else
        zero_hit_s     = 1'b0;
`endif
    end

    twobitmultiplier u_cell (
        .A0 (a_dig_s[0]),
        .A1 (a_dig_s[1]),
        .B0 (b_dig_s[0]),
        .B1 (b_dig_s[1]),
        .P  (pp_s)
    );

    // Control FSM with registered handshakes and the shift-accumulate datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            product   <= '0;
            a_reg_r   <= '0;
            b_reg_r   <= '0;
            i_r       <= '0;
            j_r       <= '0;
            acc_r     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg_r  <= a;
                        b_reg_r  <= b;
                        acc_r    <= '0;
                        i_r      <= '0;
                        j_r      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state_r  <= CALC;
                    end
                end
                CALC: begin
                    // A zero operand is detected on the first CALC cycle, one cycle after accept
                    if (zero_hit_s) begin
                        acc_r     <= '0;
                        product   <= '0;
                        out_valid <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        acc_r <= acc_next_s;
                        if (j_r == LAST_DIGIT) begin
                            j_r <= '0;
                            if (i_r == LAST_DIGIT) begin
                                i_r       <= '0;
                                product   <= acc_next_s;
                                out_valid <= 1'b1;
                                state_r   <= DONE;
                            end else begin
                                i_r <= i_r + ONE_DIGIT;
                            end
                        end else begin
                            j_r <= j_r + ONE_DIGIT;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: directed WIDTH=8 cases plus random runs at WIDTH 2/4/8/16.
module tb_mult_seq_ctrl;

    localparam int DIG8 = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_aux_n;
    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        out_valid8;
    logic        out_ready8;
    logic [15:0] product8;
    logic        busy8;
    logic        or_dir;
    logic        or_rnd = 1'b0;
    logic        rand_phase;

    int checks = 0;
    int errors = 0;
    int pops8  = 0;
    logic [15:0] q8[$];

    always #5 clk = ~clk;

    assign out_ready8 = rand_phase ? or_rnd : or_dir;

    mult_seq_ctrl #(.WIDTH(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .product   (product8),
        .busy      (busy8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Reference latency: every digit pair costs one cycle, unless zero skip applies.
    function automatic int lat_ref8(input logic [7:0] av, input logic [7:0] bv);
`ifdef MULT_ZERO_SKIP_EN
        if (av == 8'h00 || bv == 8'h00) return 1;
`endif
        return DIG8 * DIG8;
    endfunction

    task automatic send8(input logic [7:0] av, input logic [7:0] bv, input bit push);
        int n = 0;
        @(posedge clk); #1;
        in_valid8 = 1'b1;
        a8 = av;
        b8 = bv;
        @(negedge clk);
        while (!in_ready8 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready8) fail_now("accept_timeout");
        else if (push) q8.push_back({8'h00, av} * {8'h00, bv});
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic wait_valid(output int n, output int bad);
        n = 0;
        bad = 0;
        while (!out_valid8 && n < 2000) begin
            if (in_ready8) bad++;
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid8) fail_now("valid_timeout");
    endtask

    logic        stall_r = 1'b0;
    logic [15:0] stall_p = 16'h0000;

    always @(posedge clk) begin
        #1 or_rnd = 1'($urandom_range(0, 1));
    end

    // WIDTH=8 monitor: pops the scoreboard on each handshake and checks hold under back-pressure
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_r) begin
                chk("hold_valid", 32'(out_valid8), 32'd1);
                chk("hold_product", 32'(product8), 32'(stall_p));
            end
            if (out_valid8 && out_ready8) begin
                if (q8.size() == 0) fail_now("unexpected_product8");
                else begin
                    chk("product8", 32'(product8), 32'(q8.pop_front()));
                    pops8++;
                end
            end
            stall_r = out_valid8 && !out_ready8;
            stall_p = product8;
        end else begin
            stall_r = 1'b0;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_aux
        localparam int W = (g == 0) ? 2 : ((g == 1) ? 4 : 16);
        logic            iv = 1'b0;
        logic            ir;
        logic            ov;
        logic            orr = 1'b0;
        logic            bz;
        logic [W-1:0]    av = '0;
        logic [W-1:0]    bv = '0;
        logic [2*W-1:0]  pr;
        logic [2*W-1:0]  q[$];
        bit              done = 1'b0;

        mult_seq_ctrl #(.WIDTH(W)) u_dut (
            .clk       (clk),
            .rst_n     (rst_aux_n),
            .in_valid  (iv),
            .in_ready  (ir),
            .a         (av),
            .b         (bv),
            .out_valid (ov),
            .out_ready (orr),
            .product   (pr),
            .busy      (bz)
        );

        always @(posedge clk) begin
            #1 orr = 1'($urandom_range(0, 1));
        end

        initial begin
            int n;
            repeat (5) @(posedge clk);
            for (int k = 0; k < 250; k++) begin
                @(posedge clk); #1;
                iv = 1'b1;
                av = W'($urandom);
                bv = W'($urandom);
                if ($urandom_range(0, 7) == 0) av = '0;
                n = 0;
                @(negedge clk);
                while (!ir && n < 5000) begin
                    @(negedge clk);
                    n++;
                end
                if (!ir) fail_now("aux_accept_timeout");
                else q.push_back({{W{1'b0}}, av} * {{W{1'b0}}, bv});
                @(posedge clk); #1;
                iv = 1'b0;
            end
            n = 0;
            while (q.size() != 0 && n < 2000) begin
                @(posedge clk);
                n++;
            end
            if (q.size() != 0) fail_now("aux_drain_timeout");
            done = 1'b1;
        end

        always @(negedge clk) begin
            if (rst_aux_n && ov && orr) begin
                if (q.size() == 0) fail_now("unexpected_product_aux");
                else chk($sformatf("product_w%0d", W), 32'(pr), 32'(q.pop_front()));
            end
        end
    end

    initial begin
        int n;
        int bad;
        int p0;
        logic [7:0] ra;
        logic [7:0] rb;
        rst_n = 1'b0;
        rst_aux_n = 1'b0;
        in_valid8 = 1'b0;
        a8 = 8'h00;
        b8 = 8'h00;
        or_dir = 1'b1;
        rand_phase = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready8), 32'd1);
        chk("rst_out_valid", 32'(out_valid8), 32'd0);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_product", 32'(product8), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        rst_aux_n = 1'b1;

        // Full-scale operands
        send8(8'hFF, 8'hFF, 1'b1);
        wait_valid(n, bad);
        chk("lat_ffff", 32'(n), 32'(lat_ref8(8'hFF, 8'hFF)));
        chk("in_ready_low_ffff", 32'(bad), 32'd0);
        chk("busy_in_done", 32'(busy8), 32'd1);
        repeat (2) begin @(posedge clk); #1; end
        chk("idle_in_ready", 32'(in_ready8), 32'd1);
        chk("idle_busy", 32'(busy8), 32'd0);

        // Zero operand
        send8(8'h37, 8'h00, 1'b1);
        wait_valid(n, bad);
        chk("lat_zero", 32'(n), 32'(lat_ref8(8'h37, 8'h00)));
        repeat (2) begin @(posedge clk); #1; end

        // Back-pressure for five cycles
        or_dir = 1'b0;
        send8(8'h12, 8'h34, 1'b1);
        wait_valid(n, bad);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_product", 32'(product8), 32'h0000_03A8);
        end
        @(posedge clk); #1;
        or_dir = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(out_valid8), 32'd0);
        chk("bp_release_ready", 32'(in_ready8), 32'd1);

        // Second pair offered while busy must wait for the first result
        send8(8'h0A, 8'h0B, 1'b1);
        p0 = pops8;
        send8(8'hFF, 8'hFF, 1'b1);
        chk("no_early_accept", 32'(pops8), 32'(p0 + 1));
        wait_valid(n, bad);
        repeat (2) begin @(posedge clk); #1; end

        // Reset during CALC discards the operation
        send8(8'hC3, 8'h5A, 1'b0);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready8), 32'd1);
        chk("midrst_out_valid", 32'(out_valid8), 32'd0);
        chk("midrst_busy", 32'(busy8), 32'd0);
        chk("midrst_product", 32'(product8), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        send8(8'h03, 8'h03, 1'b1);
        wait_valid(n, bad);
        chk("lat_after_reset", 32'(n), 32'(lat_ref8(8'h03, 8'h03)));
        repeat (3) begin @(posedge clk); #1; end

        // Random regression with random consumer stalls
        rand_phase = 1'b1;
        for (int k = 0; k < 250; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 9) == 0) rb = 8'h00;
            send8(ra, rb, 1'b1);
        end
        n = 0;
        while (q8.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        if (q8.size() != 0) fail_now("drain8_timeout");
        rand_phase = 1'b0;

        n = 0;
        while (!(g_aux[0].done && g_aux[1].done && g_aux[2].done) && n < 60000) begin
            @(posedge clk);
            n++;
        end
        if (!(g_aux[0].done && g_aux[1].done && g_aux[2].done)) fail_now("aux_done_timeout");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
